truth_table_scanner: RTL and testbench
======================================

Name: truth_table_scanner

Overview:
Sequential reader for the sum-of-products truth-table functions. On `start`, the block sweeps every input combination to a combinational function under test. For each combination it waits for the function output to settle, samples the single-bit output, and builds the minterm mask and the minterm count. This lets the team recover a function's minterm list in hardware, where a testbench would otherwise print the table.

Parameters:
N_VARS, 4, number of function inputs; legal 2..6; vars_out[N_VARS-1] is the first variable (x), bit 0 the last (z).
SETTLE_CYCLES, 1, number of idle cycles each vector is held before sampling; legal 0..15.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
start  input  1  request a scan; accepted only in IDLE.
f_in  input  1  output of the function under test, driven from vars_out.
vars_out  output  N_VARS  current input combination {x,y,(w),z}.
busy  output  1  high from the cycle after start is accepted through the final sample.
done  output  1  one-cycle pulse when the results are valid.
minterms  output  2**N_VARS  bit i = f(i); valid from done until the next accepted start.
count  output  N_VARS+1  number of ones in minterms (0..2**N_VARS).

Behaviour:
- Reset (async assert, synchronous release):
  - State goes to IDLE.
  - vars_out=0, busy=0, done=0, minterms=0, count=0.
  - The settle counter is cleared.
- States:
  - IDLE: waits for start.
  - SETTLE: holds vars_out for SETTLE_CYCLES cycles.
  - SAMPLE: captures f_in.
  - DONE: pulses done.
- IDLE with start=1 at an edge:
  - minterms and count are cleared.
  - vars_out=0, busy=1.
  - Next state is SETTLE, or SAMPLE directly if SETTLE_CYCLES=0.
- SETTLE: the counter counts 0..SETTLE_CYCLES-1, then the state moves to SAMPLE.
- SAMPLE, at the edge:
  - minterms[vars_out] <= f_in.
  - count <= count + f_in.
  - If vars_out == 2**N_VARS-1, next state is DONE. Otherwise vars_out increments and the state returns to SETTLE (or stays in SAMPLE when SETTLE_CYCLES=0).
- Each vector occupies exactly SETTLE_CYCLES+1 cycles. f_in is sampled on the last of those cycles.
- DONE:
  - done=1 for one cycle, busy=0.
  - vars_out returns to 0.
  - Next state is IDLE.
  - minterms and count hold their values.
- Latency: with start accepted at edge 0, done is high during the cycle after edge 2**N_VARS*(SETTLE_CYCLES+1)+1.
  - N_VARS=4, SETTLE_CYCLES=1: done after edge 33.
  - N_VARS=3, SETTLE_CYCLES=0: done after edge 9.
- start while busy or in DONE is ignored; there is no queueing. start held high continuously produces back-to-back scans, each re-accepted in IDLE.
- vars_out never exceeds 2**N_VARS-1. The wrap from the last vector goes through DONE, never directly to 0 in SAMPLE.
- count never overflows: its width is N_VARS+1, so the all-ones function yields exactly 2**N_VARS.
- rst_n asserted mid-scan aborts immediately to the reset values. Partial results are discarded and no done is issued.
- Outputs are registered. f_in is the only input consumed combinationally (into the sample register).

Decomposition:
- Shared package tt_scan_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE, DONE);
  - the localparams NUM_VECTORS = 2**N_VARS and LAST_VECTOR = NUM_VECTORS-1;
  - the width helper for count.
- Natural sub-module tt_settle_timer:
  - loadable down-counter of width 4;
  - inputs: load, SETTLE_CYCLES value;
  - output: expired.
- The FSM, vector counter and accumulator stay in the top module.

Test Plan:
1. N_VARS=3, SETTLE_CYCLES=1, f = ~x&y&~z | x&~y&z | x&y&~z | x&y&z, one start pulse -> minterms=8'hE4, count=4, done pulse exactly once, 17 cycles after start.
2. N_VARS=3, SETTLE_CYCLES=0, f = ~x&~y&z | ~x&y&z | x&y&~z | x&y&z -> minterms=8'hCA, count=4; vars_out steps 0..7, one per cycle.
3. N_VARS=4, SETTLE_CYCLES=1:
   - seven-minterm function (minterms 1,2,4,6,7,12,15) -> minterms=16'h90D6, count=7;
   - second scan of the minterms 0,2,5,7,9,13 function -> minterms=16'h22A5, count=6; previous results cleared on start.
4. N_VARS=4, f tied 1 -> minterms=16'hFFFF, count=16 (5'b10000); f tied 0 -> minterms=0, count=0.
5. start pulsed again at vectors 3 and 9 of a running scan -> ignored; single done after 33 cycles; result unchanged.
6. rst_n dropped asynchronously mid-cycle at vector 6 -> outputs zero immediately without a clock edge, no done pulse; a fresh start after release completes a normal scan.

Source files
------------

// File: rtl/truth_table_scanner_pkg.sv
// rtl/truth_table_scanner_pkg.sv - shared types and sizing helpers for the truth-table scanner
package tt_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam int DEFAULT_N_VARS = 4;
  localparam int NUM_VECTORS    = 2 ** DEFAULT_N_VARS;
  localparam int LAST_VECTOR    = NUM_VECTORS - 1;

  function automatic int num_vectors(input int n_vars);
    return 1 << n_vars;
  endfunction

  // One extra bit so an all-ones function counts to exactly 2**n_vars.
  function automatic int count_width(input int n_vars);
    return n_vars + 1;
  endfunction

endpackage

// File: rtl/truth_table_scanner_if.sv
// rtl/truth_table_scanner_if.sv - scan request, function-under-test and result signals
interface truth_table_scanner_if
  import tt_scan_pkg::*;
#(
  parameter int N_VARS = DEFAULT_N_VARS
);

  logic                              start;
  logic                              f_in;
  logic [N_VARS-1:0]                 vars_out;
  logic                              busy;
  logic                              done;
  logic [num_vectors(N_VARS)-1:0]    minterms;
  logic [count_width(N_VARS)-1:0]    count;

  modport master (
    output start,
    output f_in,
    input  vars_out,
    input  busy,
    input  done,
    input  minterms,
    input  count
  );

  modport slave (
    input  start,
    input  f_in,
    output vars_out,
    output busy,
    output done,
    output minterms,
    output count
  );

endinterface

// File: rtl/tt_settle_timer.sv
// rtl/tt_settle_timer.sv - loadable 4-bit down-counter timing the settle window
module tt_settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] value,
  output logic       expired
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign expired = (cnt == 4'd0);

endmodule

// File: rtl/truth_table_scanner.sv
// rtl/truth_table_scanner.sv - sweeps all input vectors of a function and collects its minterm mask
module truth_table_scanner
  import tt_scan_pkg::*;
#(
  parameter int N_VARS        = DEFAULT_N_VARS,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_scanner_if.slave  bus
);

  localparam int                NUM_VEC = num_vectors(N_VARS);
  localparam int                CW      = count_width(N_VARS);
  localparam logic [N_VARS-1:0] LAST_V  = N_VARS'(NUM_VEC - 1);
  // Timer is loaded with SETTLE_CYCLES-1 so that expired rises on the last settle cycle.
  localparam logic [3:0] SETTLE_LOAD = 4'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam state_t     AFTER_VEC   = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

  state_t              state;
  logic [N_VARS-1:0]   vars_q;
  logic                busy_q;
  logic                done_q;
  logic [NUM_VEC-1:0]  minterms_q;
  logic [CW-1:0]       count_q;
  logic                timer_load;
  logic                timer_expired;

  assign timer_load = ((state == IDLE) && bus.start) ||
                      ((state == SAMPLE) && (vars_q != LAST_V));

  tt_settle_timer u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .value   (SETTLE_LOAD),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vars_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      minterms_q <= '0;
      count_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            minterms_q <= '0;
            count_q    <= '0;
            vars_q     <= '0;
            busy_q     <= 1'b1;
            state      <= AFTER_VEC;
          end
        end
        SETTLE: begin
          if (timer_expired) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          minterms_q[vars_q] <= bus.f_in;
          count_q            <= count_q + CW'(bus.f_in);
          // The last vector exits through DONE so vars_out never wraps inside the sweep.
          if (vars_q == LAST_V) begin
            state <= DONE;
          end else begin
            vars_q <= vars_q + N_VARS'(1);
            state  <= AFTER_VEC;
          end
        end
        DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          vars_q <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.vars_out = vars_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.minterms = minterms_q;
  assign bus.count    = count_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb/tb_truth_table_scanner.sv - scoreboard bench for three scanner configurations
module tb_truth_table_scanner;

  typedef struct {
    logic [15:0] mask;
    logic [4:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start_v = 3'b000;
  logic [7:0]  tt31 = 8'h00;
  logic [7:0]  tt30 = 8'h00;
  logic [15:0] tt41 = 16'h0000;
  exp_t        sb[$];
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  truth_table_scanner_if #(.N_VARS(3)) i31 ();
  truth_table_scanner_if #(.N_VARS(3)) i30 ();
  truth_table_scanner_if #(.N_VARS(4)) i41 ();

  assign i31.start = start_v[0];
  assign i30.start = start_v[1];
  assign i41.start = start_v[2];
  assign i31.f_in  = tt31[i31.vars_out];
  assign i30.f_in  = tt30[i30.vars_out];
  assign i41.f_in  = tt41[i41.vars_out];

  truth_table_scanner #(.N_VARS(3), .SETTLE_CYCLES(1)) d31 (.clk(clk), .rst_n(rst_n), .bus(i31));
  truth_table_scanner #(.N_VARS(3), .SETTLE_CYCLES(0)) d30 (.clk(clk), .rst_n(rst_n), .bus(i30));
  truth_table_scanner #(.N_VARS(4), .SETTLE_CYCLES(1)) d41 (.clk(clk), .rst_n(rst_n), .bus(i41));

  function automatic logic get_done(input int d);
    case (d)
      0:       return i31.done;
      1:       return i30.done;
      default: return i41.done;
    endcase
  endfunction

  function automatic logic get_busy(input int d);
    case (d)
      0:       return i31.busy;
      1:       return i30.busy;
      default: return i41.busy;
    endcase
  endfunction

  function automatic logic [3:0] get_vars(input int d);
    case (d)
      0:       return {1'b0, i31.vars_out};
      1:       return {1'b0, i30.vars_out};
      default: return i41.vars_out;
    endcase
  endfunction

  function automatic logic [15:0] get_mins(input int d);
    case (d)
      0:       return {8'h00, i31.minterms};
      1:       return {8'h00, i30.minterms};
      default: return i41.minterms;
    endcase
  endfunction

  function automatic logic [4:0] get_cnt(input int d);
    case (d)
      0:       return {1'b0, i31.count};
      1:       return {1'b0, i30.count};
      default: return i41.count;
    endcase
  endfunction

  function automatic logic [15:0] mask_of(input int list[$]);
    logic [15:0] m = 16'h0;
    foreach (list[i]) m[list[i]] = 1'b1;
    return m;
  endfunction

  task automatic push_exp(input logic [15:0] m, input logic [4:0] c);
    exp_t e;
    e.mask = m;
    e.cnt  = c;
    sb.push_back(e);
  endtask

  task automatic pop_check(input int d, input string tag);
    exp_t e;
    n_total++;
    if (sb.size() == 0) begin
      $display("FAIL %s: done with empty scoreboard", tag);
      return;
    end
    n_pass++;
    e = sb.pop_front();
    n_total++;
    if (get_mins(d) !== e.mask) $display("FAIL %s minterms: got %h want %h", tag, get_mins(d), e.mask);
    else n_pass++;
    n_total++;
    if (get_cnt(d) !== e.cnt) $display("FAIL %s count: got %0d want %0d", tag, get_cnt(d), e.cnt);
    else n_pass++;
  endtask

  // One start pulse; iteration k observes the state right after edge k-1 (start accepted at edge 0).
  task automatic scan(input int d, input int exp_lat, input bit poke, input bit step_vars, input string tag);
    int ndone = 0;
    int first = -1;
    int lim = exp_lat + 6;
    @(negedge clk);
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    for (int k = 1; k <= lim; k++) begin
      if (k == 1) begin
        n_total++;
        if (get_mins(d) !== 16'h0 || get_cnt(d) !== 5'd0 || get_busy(d) !== 1'b1)
          $display("FAIL %s start_clear: mins %h cnt %0d busy %b want 0 0 1", tag, get_mins(d), get_cnt(d), get_busy(d));
        else n_pass++;
      end
      if (step_vars && k <= 8) begin
        n_total++;
        if (get_vars(d) !== 4'(k - 1)) $display("FAIL %s vars_step: got %0d want %0d", tag, get_vars(d), k - 1);
        else n_pass++;
      end
      if (poke && (k == 7 || k == 19)) begin
        n_total++;
        if (get_vars(d) !== ((k == 7) ? 4'd3 : 4'd9))
          $display("FAIL %s poke_vector: got %0d want %0d", tag, get_vars(d), (k == 7) ? 3 : 9);
        else n_pass++;
      end
      start_v[d] = poke && (k == 7 || k == 19);
      if (get_done(d)) begin
        ndone++;
        if (first < 0) begin
          first = k - 1;
          pop_check(d, tag);
        end
      end
      @(negedge clk);
    end
    start_v[d] = 1'b0;
    n_total++;
    if (ndone !== 1) $display("FAIL %s done_pulses: got %0d want 1", tag, ndone);
    else n_pass++;
    n_total++;
    if (first !== exp_lat) $display("FAIL %s latency: done after edge %0d want %0d", tag, first, exp_lat);
    else n_pass++;
    sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_total++;
      if (get_vars(d) !== 4'd0 || get_busy(d) !== 1'b0 || get_done(d) !== 1'b0 ||
          get_mins(d) !== 16'h0 || get_cnt(d) !== 5'd0)
        $display("FAIL reset_state[%0d]: vars %0d busy %b done %b mins %h cnt %0d want all 0",
                 d, get_vars(d), get_busy(d), get_done(d), get_mins(d), get_cnt(d));
      else n_pass++;
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_three_var_settle();
    for (int i = 0; i < 8; i++) begin
      logic [2:0] b = 3'(i);
      tt31[i] = (~b[2] & b[1] & ~b[0]) | (b[2] & ~b[1] & b[0]) | (b[2] & b[1] & ~b[0]) | (b[2] & b[1] & b[0]);
    end
    push_exp(16'h00E4, 5'd4);
    scan(0, 17, 1'b0, 1'b0, "n3s1");
  endtask

  task automatic test_three_var_no_settle();
    for (int i = 0; i < 8; i++) begin
      logic [2:0] b = 3'(i);
      tt30[i] = (~b[2] & ~b[1] & b[0]) | (~b[2] & b[1] & b[0]) | (b[2] & b[1] & ~b[0]) | (b[2] & b[1] & b[0]);
    end
    push_exp(16'h00CA, 5'd4);
    scan(1, 9, 1'b0, 1'b1, "n3s0");
  endtask

  task automatic test_four_var_rescan();
    tt41 = mask_of('{1, 2, 4, 6, 7, 12, 15});
    push_exp(16'h90D6, 5'd7);
    scan(2, 33, 1'b0, 1'b0, "n4_first");
    tt41 = mask_of('{0, 2, 5, 7, 9, 13});
    push_exp(16'h22A5, 5'd6);
    scan(2, 33, 1'b0, 1'b0, "n4_second");
  endtask

  task automatic test_constant_functions();
    tt41 = 16'hFFFF;
    push_exp(16'hFFFF, 5'b10000);
    scan(2, 33, 1'b0, 1'b0, "tied1");
    tt41 = 16'h0000;
    push_exp(16'h0000, 5'd0);
    scan(2, 33, 1'b0, 1'b0, "tied0");
  endtask

  task automatic test_start_ignored();
    tt41 = mask_of('{1, 2, 4, 6, 7, 12, 15});
    push_exp(16'h90D6, 5'd7);
    scan(2, 33, 1'b1, 1'b0, "busy_start");
  endtask

  task automatic test_back_to_back();
    int dones[$];
    tt41 = mask_of('{0, 2, 5, 7, 9, 13});
    push_exp(16'h22A5, 5'd6);
    push_exp(16'h22A5, 5'd6);
    @(negedge clk);
    start_v[2] = 1'b1;
    for (int k = 1; k <= 72; k++) begin
      @(negedge clk);
      if (k == 50) start_v[2] = 1'b0;
      if (get_done(2)) begin
        dones.push_back(k - 1);
        pop_check(2, "b2b");
      end
    end
    n_total++;
    if (dones.size() != 2 || dones[0] != 33 || dones[1] != 67)
      $display("FAIL b2b_timing: got %0d dones first %0d second %0d want 2 at 33 67", dones.size(),
               (dones.size() > 0) ? dones[0] : -1, (dones.size() > 1) ? dones[1] : -1);
    else n_pass++;
    sb.delete();
  endtask

  task automatic test_async_reset();
    int ndone = 0;
    tt41 = mask_of('{1, 2, 4, 6, 7, 12, 15});
    @(negedge clk);
    start_v[2] = 1'b1;
    @(negedge clk);
    start_v[2] = 1'b0;
    repeat (12) @(negedge clk);
    n_total++;
    if (get_vars(2) !== 4'd6 || get_mins(2) === 16'h0)
      $display("FAIL abort_precond: vars %0d mins %h want 6 and nonzero", get_vars(2), get_mins(2));
    else n_pass++;
    #3 rst_n = 1'b0;
    #1;
    n_total++;
    if (get_vars(2) !== 4'd0 || get_busy(2) !== 1'b0 || get_mins(2) !== 16'h0 || get_cnt(2) !== 5'd0)
      $display("FAIL abort_outputs: vars %0d busy %b mins %h cnt %0d want 0", get_vars(2), get_busy(2),
               get_mins(2), get_cnt(2));
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (get_done(2)) ndone++;
    end
    n_total++;
    if (ndone !== 0) $display("FAIL abort_no_done: got %0d done pulses want 0", ndone);
    else n_pass++;
    push_exp(16'h90D6, 5'd7);
    scan(2, 33, 1'b0, 1'b0, "after_abort");
  endtask

  initial begin
    test_reset();
    test_three_var_settle();
    test_three_var_no_settle();
    test_four_var_rescan();
    test_constant_functions();
    test_start_ignored();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
